// File: rtl/keypad_scan_fifo.sv
// 4x4 keypad scanner with frame debounce and a small key-code FIFO read by a CPU strobe.
// Optional build macro KEYPAD_OVERFLOW_FLAG_EN adds a sticky overflow status bit.
module keypad_scan_fifo #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4,
  parameter int DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] rowwrite,
  input  logic [3:0] colread,
  input  logic       ack,
  input  logic       statusordata,
  output logic [3:0] keyout
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD} state_t;

  // ---------------- column synchronizer ----------------
  // Resets to the released (pulled-up) level so no phantom press is seen.
  logic [1:0][3:0] col_sync;
  logic [3:0]      col_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) col_sync <= '1;
    else        col_sync <= {col_sync[0], colread};
  end
  assign col_s = col_sync[1];

  // ---------------- row scan ----------------
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       row;
  logic             slot_end;

  assign slot_end = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign rowwrite = ~(4'b0001 << row);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      row     <= 2'd0;
    end else if (slot_end) begin
      div_cnt <= '0;
      row     <= row + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // ---------------- frame reduction ----------------
  logic       row_hit, frame_hit, cur_hit, frame_done;
  logic [1:0] row_col;
  logic [3:0] frame_code, cur_code;

  always_comb begin
    row_hit = 1'b0;
    row_col = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!col_s[c]) begin
        row_hit = 1'b1;
        row_col = 2'(c);
      end
    end
  end

  // Rows are visited in ascending order, so the first hit of a frame is its lowest code.
  assign cur_hit    = frame_hit | row_hit;
  assign cur_code   = frame_hit ? frame_code : {row, row_col};
  assign frame_done = slot_end && (row == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_hit  <= 1'b0;
      frame_code <= 4'h0;
    end else if (slot_end) begin
      if (row == 2'd3) begin
        frame_hit  <= 1'b0;
        frame_code <= 4'h0;
      end else begin
        frame_hit  <= cur_hit;
        frame_code <= cur_code;
      end
    end
  end

  // ---------------- debounce FSM ----------------
  state_t          state, state_nxt;
  logic [3:0]      cand, cand_nxt;
  logic [DB_W-1:0] stable_cnt, stable_nxt;
  logic            push_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cand       <= 4'h0;
      stable_cnt <= '0;
    end else begin
      state      <= state_nxt;
      cand       <= cand_nxt;
      stable_cnt <= stable_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    stable_nxt = stable_cnt;
    push_req   = 1'b0;
    if (frame_done) begin
      case (state)
        S_IDLE: begin
          if (cur_hit) begin
            cand_nxt   = cur_code;
            stable_nxt = DB_W'(1);
            state_nxt  = S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (!cur_hit) begin
            stable_nxt = '0;
            state_nxt  = S_IDLE;
          end else if (cur_code == cand) begin
            stable_nxt = stable_cnt + DB_W'(1);
            if (stable_cnt >= DB_W'(DEBOUNCE - 1)) begin
              push_req  = 1'b1;
              state_nxt = S_HELD;
            end
          end else begin
            cand_nxt   = cur_code;
            stable_nxt = DB_W'(1);
          end
        end
        S_HELD: begin
          if (!cur_hit) begin
            stable_nxt = '0;
            state_nxt  = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------- key FIFO ----------------
  logic [3:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             ack_d, ack_rise, full, not_empty, push, pop, ovf;

  assign full      = (count == CNT_W'(DEPTH));
  assign not_empty = (count != '0);
  assign ack_rise  = ack & ~ack_d;
  // Only a data read consumes an entry; a status read leaves the queue alone.
  assign pop       = ack_rise & ~statusordata & not_empty;
  assign push      = push_req & ~full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ack_d  <= 1'b0;
    end else begin
      ack_d <= ack;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef KEYPAD_OVERFLOW_FLAG_EN
  // A new overflow in the same cycle as a status read wins, so it is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ovf <= 1'b0;
    else if (push_req && full)         ovf <= 1'b1;
    else if (ack_rise && statusordata) ovf <= 1'b0;
  end
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    keyout = 4'h0;
    if (statusordata)   keyout = {1'b0, full, ovf, not_empty};
    else if (not_empty) keyout = mem[rd_ptr];
  end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: frame-level behavioural model checked every cycle, plus literal spot checks.
module tb_keypad_scan_fifo;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int DEPTH    = 4;
  localparam int FRAME    = 4 * SCAN_DIV;
`ifdef KEYPAD_OVERFLOW_FLAG_EN
  localparam logic [3:0] FULL_OVF_STAT = 4'h7;
  localparam logic [3:0] DRAINED_STAT  = 4'h2;
`else
  localparam logic [3:0] FULL_OVF_STAT = 4'h5;
  localparam logic [3:0] DRAINED_STAT  = 4'h0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, ack = 1'b0, statusordata = 1'b0;
  logic [3:0]  rowwrite, colread, keyout;
  logic [15:0] keys = '0;
  int          checks = 0, failures = 0;
  logic        cmp_en = 1'b0;

  keypad_scan_fifo #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rowwrite(rowwrite), .colread(colread),
    .ack(ack), .statusordata(statusordata), .keyout(keyout)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    colread = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rowwrite[r] && keys[4*r+c]) colread[c] = 1'b0;
  end

  // ---------------- frame-level model ----------------
  int         mk = 0, run_key = -1, run_len = 0, res = -1;
  logic [3:0] q[$];
  logic       m_ovf = 1'b0, m_ack_d = 1'b0, pushed = 1'b0;
  logic       rise, do_pop, do_push, full_b;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mk = 0; q.delete(); m_ovf = 1'b0; m_ack_d = 1'b0;
        run_key = -1; run_len = 0; pushed = 1'b0;
      end else begin
        mk++;
        rise    = ack && !m_ack_d;
        m_ack_d = ack;
        full_b  = (q.size() == DEPTH);
        do_pop  = rise && !statusordata && (q.size() > 0);
        do_push = 1'b0;
        if (mk % FRAME == 0) begin
          res = -1;
          for (int i = 15; i >= 0; i--) if (keys[i]) res = i;
          if (res < 0) begin
            run_key = -1; run_len = 0; pushed = 1'b0;
          end else begin
            if (res == run_key) run_len++;
            else begin run_key = res; run_len = 1; end
            if (run_len == DEBOUNCE && !pushed) begin do_push = 1'b1; pushed = 1'b1; end
          end
        end
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          if (full_b) begin
`ifdef KEYPAD_OVERFLOW_FLAG_EN
            m_ovf = 1'b1;
`endif
          end else q.push_back(4'(res));
        end
        if (rise && statusordata && !(do_push && full_b)) m_ovf = 1'b0;
      end
    end
  end

  function automatic logic [3:0] model_keyout();
    if (statusordata) return {1'b0, q.size() == DEPTH, m_ovf, q.size() != 0};
    if (q.size() != 0) return q[0];
    return 4'h0;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("rowwrite_cyc", rowwrite, ~(4'b0001 << ((mk / SCAN_DIV) % 4)));
        check("keyout_cyc", keyout, model_keyout());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align();
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk); #1;
      if (mk % FRAME == 0) return;
    end
    failures++;
    $display("FAIL align: frame boundary not reached, got mk=%0d expected multiple of %0d", mk, FRAME);
  endtask

  task automatic press(input int code, input int nfr);
    align();
    keys = 16'(1) << code;
    wait_cyc(nfr * FRAME);
    keys = '0;
    wait_cyc(FRAME);
  endtask

  task automatic ack_pulse(input int w, input logic sod);
    statusordata = sod;
    ack = 1'b1;
    wait_cyc(w);
    ack = 1'b0;
    statusordata = 1'b0;
    wait_cyc(1);
  endtask

  task automatic peek(input string name, input logic sod, input logic [3:0] exp);
    statusordata = sod;
    #1;
    check(name, keyout, exp);
    statusordata = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check("rst_rowwrite", rowwrite, 4'b1110);
    peek("rst_data", 1'b0, 4'h0);
    peek("rst_status", 1'b1, 4'h0);
    rst_n = 1'b1;

    // key 6 held three frames: one push
    press(6, 3);
    peek("k6_status", 1'b1, 4'h1);
    peek("k6_data", 1'b0, 4'h6);
    ack_pulse(1, 1'b0);
    peek("k6_popped", 1'b0, 4'h0);

    // one-frame glitch on key 5: no push
    press(5, 1);
    wait_cyc(FRAME);
    peek("glitch_status", 1'b1, 4'h0);

    // fill, then overflow with key 0
    press(3, 3); press(7, 3); press(9, 3); press(12, 3);
    press(0, 3);
    peek("full_status", 1'b1, FULL_OVF_STAT);
    peek("pop3", 1'b0, 4'd3);  ack_pulse(1, 1'b0);
    peek("pop7", 1'b0, 4'd7);  ack_pulse(1, 1'b0);
    peek("pop9", 1'b0, 4'd9);  ack_pulse(1, 1'b0);
    peek("pop12", 1'b0, 4'd12); ack_pulse(1, 1'b0);
    peek("drained_data", 1'b0, 4'h0);
    peek("drained_status", 1'b1, DRAINED_STAT);
    ack_pulse(1, 1'b1);
    peek("status_read_clr", 1'b1, 4'h0);

    // long ack strobe pops once
    press(1, 3); press(2, 3);
    ack_pulse(10, 1'b0);
    peek("long_ack_data", 1'b0, 4'd2);
    peek("long_ack_status", 1'b1, 4'h1);
    ack_pulse(1, 1'b0);
    peek("long_ack_empty", 1'b1, 4'h0);

    // push lands on the same edge as an ack rising edge
    press(4, 3); press(8, 3);
    align();
    keys = 16'(1) << 10;
    wait_cyc(2 * FRAME - 1);
    ack = 1'b1;
    wait_cyc(1);
    ack = 1'b0;
    keys = '0;
    wait_cyc(FRAME);
    peek("same_cyc_status", 1'b1, 4'h1);
    peek("same_cyc_head8", 1'b0, 4'd8);
    ack_pulse(1, 1'b0);
    peek("same_cyc_head10", 1'b0, 4'd10);
    ack_pulse(1, 1'b0);
    peek("same_cyc_empty", 1'b0, 4'h0);

    // reset mid-debounce with three entries queued
    press(1, 3); press(2, 3); press(3, 3);
    align();
    keys = 16'(1) << 5;
    wait_cyc(FRAME + 5);
    rst_n = 1'b0;
    keys = '0;
    #1;
    check("midrst_rowwrite", rowwrite, 4'b1110);
    peek("midrst_data", 1'b0, 4'h0);
    peek("midrst_status", 1'b1, 4'h0);
    wait_cyc(2);
    rst_n = 1'b1;
    press(11, 3);
    peek("post_rst_data", 1'b0, 4'd11);
    peek("post_rst_status", 1'b1, 4'h1);

    wait_cyc(4);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
